// File: rtl/int_ctrl.sv
// Multi-channel interrupt controller: synchronised sticky pending bits, mask, edge/level mode, priority request FSM.
// Latency: int_in -> pending after SYNC_STAGES edges, -> irq one edge later; rdata one edge after addr.
// Backpressure: one request in flight; later events stay pending until eoi returns the FSM to IDLE.
module int_ctrl #(
    parameter int              N_CH        = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] MODE_RST    = {N_CH{1'b1}},
    localparam int             ID_W        = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] int_in,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [N_CH-1:0] wdata,
    output logic [N_CH-1:0] rdata,
    output logic            irq,
    output logic [ID_W-1:0] irq_id,
    input  logic            ack,
    input  logic            eoi
);

    localparam logic [1:0]      ADDR_PENDING = 2'd0;
    localparam logic [1:0]      ADDR_MASK    = 2'd1;
    localparam logic [1:0]      ADDR_MODE    = 2'd2;
    localparam logic [N_CH-1:0] ONE          = {{(N_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [N_CH-1:0] r_sync [SYNC_STAGES];
    logic [N_CH-1:0] w_s;
    logic [N_CH-1:0] r_s_prev;

    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] w_pending_nxt;
    logic [N_CH-1:0] r_mask;
    logic [N_CH-1:0] r_mode;
    logic [N_CH-1:0] w_set;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_elig;
    logic [N_CH-1:0] w_id_onehot;

    logic [ID_W-1:0] r_irq_id;
    logic [ID_W-1:0] w_winner;
    logic            w_any;
    logic            r_irq;
    logic            w_irq_nxt;
    logic            w_id_load;
    logic            w_ack_take;

    logic [N_CH-1:0] w_status;
    logic [N_CH-1:0] w_rd_mux;
    logic [N_CH-1:0] r_rdata;

    // Synchroniser chain for the raw asynchronous sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= int_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Previous synchronised sample, used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_prev <= '0;
        end else begin
            r_s_prev <= w_s;
        end
    end

    // Edge-mode channels fire on a rising edge, level-mode channels on every high cycle.
    assign w_set       = (r_mode & w_s & ~r_s_prev) | (~r_mode & w_s);
    assign w_id_onehot = ONE << r_irq_id;

    // Clear sources: software write-1-to-clear and the accepted acknowledge.
    always_comb begin
        w_clr = '0;
        if (we && (addr == ADDR_PENDING)) begin
            w_clr = wdata;
        end
        if (w_ack_take) begin
            w_clr = w_clr | w_id_onehot;
        end
    end

    // A set in the same cycle as a clear keeps the bit pending.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_set;

    // Sticky pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Software-writable MASK and MODE registers; STATUS writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_mode <= MODE_RST;
        end else if (we) begin
            if (addr == ADDR_MASK) begin
                r_mask <= wdata;
            end
            if (addr == ADDR_MODE) begin
                r_mode <= wdata;
            end
        end
    end

    assign w_elig = r_pending & r_mask;
    assign w_any  = |w_elig;

    // Priority encoder: the lowest eligible index wins.
    always_comb begin
        w_winner = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // Handshake FSM state register, with the registered irq and frozen id.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
            if (w_id_load) begin
                r_irq_id <= w_winner;
            end
        end
    end

    // Handshake FSM next state: ack beats withdrawal, eoi only counts in service.
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = 1'b0;
        w_id_load   = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_REQ;
                    w_irq_nxt   = 1'b1;
                    w_id_load   = 1'b1;
                end
            end
            ST_REQ: begin
                w_irq_nxt = 1'b1;
                if (ack) begin
                    w_state_nxt = ST_SVC;
                    w_irq_nxt   = 1'b0;
                    w_ack_take  = 1'b1;
                end else if (!(r_pending[r_irq_id] && r_mask[r_irq_id])) begin
                    w_state_nxt = ST_IDLE;
                    w_irq_nxt   = 1'b0;
                end
            end
            ST_SVC: begin
                if (eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // STATUS word: busy flag in the top bit, current id in the low bits.
    always_comb begin
        w_status             = '0;
        w_status[ID_W-1:0]   = r_irq_id;
        w_status[N_CH-1]     = (r_state != ST_IDLE);
    end

    // Read mux selecting the register addressed this cycle.
    always_comb begin
        w_rd_mux = '0;
        case (addr)
            2'd0:    w_rd_mux = r_pending;
            2'd1:    w_rd_mux = r_mask;
            2'd2:    w_rd_mux = r_mode;
            default: w_rd_mux = w_status;
        endcase
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_mux;
        end
    end

    assign rdata  = r_rdata;
    assign irq    = r_irq;
    assign irq_id = r_irq_id;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random traffic, scored against a reference model.
// Model predictions are queued at each rising edge; a monitor compares DUT outputs on the falling edge.
// No flow control on the DUT side; every cycle yields one expected output record.
module tb_int_ctrl;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int IW = 3;

    bit            clk;
    logic          rst;
    logic [N-1:0]  int_in;
    logic          we;
    logic [1:0]    addr;
    logic [N-1:0]  wdata;
    logic [N-1:0]  rdata;
    logic          irq;
    logic [IW-1:0] irq_id;
    logic          ack;
    logic          eoi;

    int checks = 0;
    int errors = 0;

    int_ctrl #(
        .N_CH        (N),
        .SYNC_STAGES (SS),
        .MODE_RST    (8'hFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .int_in (int_in),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .irq_id (irq_id),
        .ack    (ack),
        .eoi    (eoi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          irq;
        logic [IW-1:0] id;
        logic [N-1:0]  rd;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_hist[$];   // m_hist[0] = newest sample of int_in
    logic [N-1:0] m_prev, m_pend, m_mask, m_mode;
    bit           m_req, m_svc;
    int           m_id;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] s, set, clr, rd;
        exp_t e;
        rd = '0;
        if (rst) begin
            m_hist = {};
            for (int i = 0; i < SS; i++) m_hist.push_back('0);
            m_prev = '0; m_pend = '0; m_mask = '0; m_mode = 8'hFF;
            m_req = 0; m_svc = 0; m_id = 0;
        end else begin
            s = m_hist[SS-1];
            case (addr)
                2'd0: rd = m_pend;
                2'd1: rd = m_mask;
                2'd2: rd = m_mode;
                default: rd = {(m_req || m_svc), 4'b0000, 3'(m_id)};
            endcase
            set = '0;
            for (int c = 0; c < N; c++) begin
                if (m_mode[c]) set[c] = s[c] && !m_prev[c];
                else           set[c] = s[c];
            end
            clr = (we && addr == 2'd0) ? wdata : '0;
            if (m_req && ack) clr[m_id] = 1'b1;
            if (m_req) begin
                if (ack) begin m_req = 0; m_svc = 1; end
                else if (!(m_pend[m_id] && m_mask[m_id])) m_req = 0;
            end else if (m_svc) begin
                if (eoi) m_svc = 0;
            end else if ((m_pend & m_mask) != 0) begin
                m_req = 1;
                m_id  = lowest(m_pend & m_mask);
            end
            m_pend = (m_pend & ~clr) | set;
            if (we && addr == 2'd1) m_mask = wdata;
            if (we && addr == 2'd2) m_mode = wdata;
            m_prev = s;
            m_hist.push_front(int_in);
            void'(m_hist.pop_back());
        end
        e.irq = m_req;
        e.id  = 3'(m_id);
        e.rd  = rd;
        sb_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected record at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            chk("sb_irq",    32'(irq),    32'(e.irq));
            chk("sb_irq_id", 32'(irq_id), 32'(e.id));
            chk("sb_rdata",  32'(rdata),  32'(e.rd));
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        int_in = v;
        @(negedge clk);
        int_in = '0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    task automatic wait_irq(input string nm, input int exp_id);
        int n = 0;
        while (irq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (irq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: irq got 0 required 1 within 20 cycles", nm);
        end else begin
            chk(nm, 32'(irq_id), 32'(exp_id));
        end
    endtask

    initial begin
        rst = 1'b1; int_in = '0; we = 1'b0; addr = 2'd0; wdata = '0; ack = 1'b0; eoi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_irq",    32'(irq),    32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_rdata",  32'(rdata),  32'd0);

        // 1: single edge pulse on channel 3, full handshake
        wr(2'd1, 8'hFF);
        addr = 2'd0;
        pulse(8'h08);
        @(negedge clk);
        @(negedge clk);
        chk("t1_irq_early", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t1_irq",  32'(irq),    32'd1);
        chk("t1_id",   32'(irq_id), 32'd3);
        chk("t1_pend", 32'(rdata),  32'h08);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; addr = 2'd3;
        chk("t1_ack_irq", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t1_status_busy", 32'(rdata), 32'h83);
        addr = 2'd0;
        @(negedge clk);
        chk("t1_pend_clr", 32'(rdata), 32'h00);
        eoi = 1'b1; addr = 2'd3;
        @(negedge clk);
        eoi = 1'b0;
        @(negedge clk);
        chk("t1_status_idle", 32'(rdata), 32'h03);

        // 2: channels 5 and 2 together, lowest index first
        pulse(8'h24);
        wait_irq("t2_first", 2);
        do_ack();
        do_eoi();
        chk("t2_gap_irq", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t2_second_irq", 32'(irq),    32'd1);
        chk("t2_second_id",  32'(irq_id), 32'd5);
        do_ack();
        do_eoi();

        // 3: level mode on channel 1
        wr(2'd2, 8'hFD);
        addr = 2'd0;
        int_in = 8'h02;
        wait_irq("t3_level", 1);
        do_ack();
        do_eoi();
        wr(2'd0, 8'h02);
        int_in = '0;
        repeat (4) @(negedge clk);
        wr(2'd0, 8'h02);
        @(negedge clk);
        chk("t3_pend_clr", 32'(rdata), 32'h00);
        wr(2'd2, 8'hFF);
        repeat (3) @(negedge clk);

        // 4: masked channel 4 latches but does not request
        wr(2'd1, 8'h00);
        addr = 2'd0;
        pulse(8'h10);
        repeat (4) @(negedge clk);
        chk("t4_masked_irq",  32'(irq),   32'd0);
        chk("t4_masked_pend", 32'(rdata), 32'h10);
        wr(2'd1, 8'h10);
        chk("t4_unmask_gap", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t4_irq", 32'(irq),    32'd1);
        chk("t4_id",  32'(irq_id), 32'd4);
        do_ack();
        do_eoi();

        // 5: software withdraws a request
        wr(2'd1, 8'hFF);
        pulse(8'h40);
        wait_irq("t5_req", 6);
        wr(2'd0, 8'h40);
        @(negedge clk);
        chk("t5_withdraw_irq", 32'(irq), 32'd0);
        addr = 2'd3;
        @(negedge clk);
        chk("t5_busy", 32'(rdata[7]), 32'd0);

        // 6: reset in the middle of service
        pulse(8'h81);
        wait_irq("t6_req", 0);
        do_ack();
        pulse(8'h01);
        addr = 2'd0;
        repeat (3) @(negedge clk);
        chk("t6_pend_before_rst", 32'(rdata), 32'h81);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_irq",   32'(irq),   32'd0);
        chk("t6_rst_rdata", 32'(rdata), 32'd0);
        do_ack();
        do_eoi();
        addr = 2'd3;
        @(negedge clk);
        chk("t6_status", 32'(rdata), 32'h00);

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) int_in = int_in ^ (N'(1) << $urandom_range(0, N-1));
            we    = ($urandom_range(0, 5) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = N'($urandom);
            ack   = ($urandom_range(0, 2) == 0);
            eoi   = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        rst = 1'b0; we = 1'b0; ack = 1'b0; eoi = 1'b0; int_in = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Parametrised multi-channel interrupt controller for the SoC. It synchronises N_CH asynchronous interrupt sources and latches each one as a sticky pending bit, in edge or level mode per channel. It masks and priority-encodes the pending bits and runs a request/acknowledge/end-of-interrupt handshake with the CPU. Software accesses it through a small register window on the system bus.

Parameters:
N_CH, 8, number of interrupt channels (2..32)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
MODE_RST, all ones, reset value of MODE register (bit i = 1: edge mode; 0: level mode)
ID_W, clog2(N_CH), localparam; width of interrupt id

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
int_in  in  N_CH  raw asynchronous interrupt sources, active-high
we  in  1  register write strobe
addr  in  2  register select: 0 PENDING, 1 MASK, 2 MODE, 3 STATUS
wdata  in  N_CH  write data
rdata  out  N_CH  registered read data for addr
irq  out  1  interrupt request to CPU
irq_id  out  ID_W  id of requested/serviced channel
ack  in  1  one-cycle CPU acknowledge
eoi  in  1  one-cycle end-of-interrupt

Behaviour:
- Reset (rst=1 at a clock edge): pending=0, MASK=0, MODE=MODE_RST, synchroniser and previous-sample flops=0, FSM=IDLE, irq=0, irq_id=0, rdata=0. Reset mid-handshake drops all pending and in-service state.
- Sync: s_i = int_in[i] after SYNC_STAGES flops.
- Set event: edge mode sets on s_i & ~s_prev_i. Level mode sets on s_i every cycle.
- Latency: int_in[i] sampled high at edge k -> pending[i]=1 after edge k+SYNC_STAGES -> irq=1 after edge k+SYNC_STAGES+1 (channel unmasked, FSM IDLE).
- Pending is sticky. Clear sources:
  - write addr 0 with wdata bit=1 (write-1-to-clear);
  - ack clears pending[irq_id].
- Set and clear in the same cycle: set wins.
- Level mode: a cleared bit re-sets the next cycle if s_i is still 1.
- Masking does not affect latching. Only pending & MASK is eligible for request.
- Priority: lowest index wins.
- Writes to addr 1 and addr 2 load MASK and MODE fully. Write to addr 3 is ignored.
- Changing MODE does not alter the pending bit.
- Reads: rdata updates one cycle after addr is presented.
  - addr 0: pending. addr 1: MASK. addr 2: MODE.
  - addr 3: bit N_CH-1 = busy (FSM != IDLE), bits ID_W-1:0 = irq_id, other bits 0.
- FSM:
  - IDLE: irq=0. If any eligible bit is set -> REQ; irq=1 and irq_id=winner, registered on the transition edge.
  - REQ: irq=1, irq_id frozen even if a higher-priority bit arrives.
    - ack=1 -> SERVICE: irq=0, pending[irq_id] cleared.
    - Else, if pending[irq_id] & MASK[irq_id]=0 (cleared or masked by software) -> IDLE with irq=0 (request withdrawn).
    - ack has priority over withdrawal in the same cycle.
  - SERVICE: irq=0, irq_id held, no nesting. eoi=1 -> IDLE.
  - The next request may be raised at the earliest one cycle after the return to IDLE.
- ack outside REQ and eoi outside SERVICE are ignored.
- ack and eoi asserted together in REQ: ack is taken, eoi is ignored.
- Events arriving during SERVICE latch normally and are requested after eoi.

Test Plan:
- Reset, MASK=0xFF, MODE=0xFF, pulse int_in[3] for 1 cycle at edge k -> pending=0x08 after k+2, irq=1 and irq_id=3 after k+3. ack -> irq=0, pending=0x00, STATUS busy=1, id=3. eoi -> busy=0.
- Channels 5 and 2 raised on the same edge -> irq_id=2 first. After ack+eoi, irq_id=5 is raised on the second cycle after eoi.
- MODE bit 1=0 (level), int_in[1] held high: ack clears pending[1] and it reads 1 again next cycle. W1C write 0x02 with input high -> pending[1] stays 1 (set wins). Input low, then W1C -> 0.
- MASK=0x00, pulse int_in[4] -> pending=0x10, irq stays 0. Write MASK=0x10 -> irq=1, irq_id=4 after 2 cycles.
- In REQ for id 6, write 0x40 to addr 0 -> FSM returns to IDLE, irq=0 next cycle, busy=0.
- rst asserted during SERVICE with pending=0x81 -> after the edge: pending=0, MASK=0, irq=0, busy=0. A subsequent ack or eoi has no effect.
